// File: rtl/av_mm_arbiter2.sv
// Two-master Avalon-MM arbiter: round-robin grants with a bounded hold count per grant.
// Transfers are never split or pre-empted; slave side is a pure mux on the grant state.
module av_mm_arbiter2 #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_write,
    input  logic              m0_read,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_write,
    input  logic              m1_read,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    output logic              s_write,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    output logic [1:0]        grant
);

    localparam int unsigned CNT_W = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        StIdle,
        StG0,
        StG1
    } state_e;

    state_e           r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;

    logic   w_req0;
    logic   w_req1;
    logic   w_req_owner;
    logic   w_req_other;
    logic   w_owner_is1;
    state_e w_other_st;

    assign w_req0      = m0_write | m0_read;
    assign w_req1      = m1_write | m1_read;
    assign w_owner_is1 = (r_state == StG1);
    assign w_req_owner = (r_state == StG0) ? w_req0 : (r_state == StG1) ? w_req1 : 1'b0;
    assign w_req_other = (r_state == StG0) ? w_req1 : (r_state == StG1) ? w_req0 : 1'b0;
    assign w_other_st  = (r_state == StG0) ? StG1 : StG0;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    // On a tie the master that did not own the bus last wins.
                    if (w_req0 && (!w_req1 || r_last)) begin
                        r_state <= StG0;
                    end else if (w_req1) begin
                        r_state <= StG1;
                    end
                end
                StG0, StG1: begin
                    if (!w_req_owner) begin
                        r_state <= w_req_other ? w_other_st : StIdle;
                        r_cnt   <= '0;
                        r_last  <= w_owner_is1;
                    end else if (!s_waitrequest) begin
                        if (w_req_other && (r_cnt == CNT_TOP)) begin
                            r_state <= w_other_st;
                            r_cnt   <= '0;
                            r_last  <= w_owner_is1;
                        end else if (r_cnt != CNT_TOP) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_write        = 1'b0;
        s_read         = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (r_state)
            StG0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_write        = m0_write;
                s_read         = m0_read;
                m0_waitrequest = s_waitrequest;
            end
            StG1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_write        = m1_write;
                s_read         = m1_read;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
            end
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign grant       = {r_state == StG1, r_state == StG0};

endmodule

// File: tb/tb_av_mm_arbiter2.sv
// Directed bench for av_mm_arbiter2: reset, solo write, contention, hold saturation,
// slave stall, read, and reset during a stalled transfer.
module tb_av_mm_arbiter2;

    logic        sysclk;
    logic        sysreset;
    logic [15:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_write, m0_read, m0_waitrequest;
    logic [15:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_write, m1_read, m1_waitrequest;
    logic [15:0] s_address, s_writedata, s_readdata;
    logic        s_write, s_read, s_waitrequest;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_pass   = 0;

    av_mm_arbiter2 #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .HOLD_MAX(4)
    ) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .m0_address    (m0_address),
        .m0_writedata  (m0_writedata),
        .m0_write      (m0_write),
        .m0_read       (m0_read),
        .m0_readdata   (m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_address    (m1_address),
        .m1_writedata  (m1_writedata),
        .m1_write      (m1_write),
        .m1_read       (m1_read),
        .m1_readdata   (m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_write       (s_write),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .grant         (grant)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic sample();
        @(negedge sysclk);
    endtask

    task automatic idle_all();
        m0_address = '0; m0_writedata = '0; m0_write = 1'b0; m0_read = 1'b0;
        m1_address = '0; m1_writedata = '0; m1_write = 1'b0; m1_read = 1'b0;
        s_readdata = '0; s_waitrequest = 1'b0;
        sysreset = 1'b1;
        tick();
        tick();
        sysreset = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        idle_all();
        sysreset = 1'b1;
        m0_write = 1'b1;
        m0_address = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            got = {s_write, grant, m0_waitrequest, s_address};
            n_checks++;
            if (got !== {1'b0, 2'b00, 1'b1, 16'h0000})
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, got, {4'b0001, 16'h0});
            else n_pass++;
        end
        sysreset = 1'b0;
        tick();
        sample();
        n_checks++;
        if ({grant, s_write} !== 3'b011)
            $display("FAIL reset_release: got %b want 011", {grant, s_write});
        else n_pass++;
        m0_write = 1'b0;
        tick();
    endtask

    task automatic test_solo_write();
        idle_all();
        m1_address = 16'h0040; m1_writedata = 16'hBEEF; m1_write = 1'b1;
        sample();
        n_checks++;
        if ({s_write, m1_waitrequest} !== 2'b01)
            $display("FAIL solo_first_cycle: got %b want 01", {s_write, m1_waitrequest});
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if ({s_address, s_writedata, s_write, m1_waitrequest, grant} !== {16'h0040, 16'hBEEF, 4'b1010})
            $display("FAIL solo_write: got %h %h %b%b%b want 0040 BEEF 1010",
                     s_address, s_writedata, s_write, m1_waitrequest, grant);
        else n_pass++;
        tick();
        m1_write = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [15:0] exp_a;
        idle_all();
        m0_address = 16'hA000; m0_writedata = 16'h0001; m0_write = 1'b1;
        m1_address = 16'hB000; m1_writedata = 16'h0002; m1_write = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            sample();
            exp_g = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = ((k / 4) % 2 == 0) ? 16'hA000 : 16'hB000;
            n_checks++;
            if ({grant, s_write, s_address} !== {exp_g, 1'b1, exp_a})
                $display("FAIL contention k=%0d: got %b %b %h want %b 1 %h",
                         k, grant, s_write, s_address, exp_g, exp_a);
            else n_pass++;
        end
        m0_write = 1'b0; m1_write = 1'b0;
        tick();
    endtask

    task automatic test_hold_saturate();
        idle_all();
        m0_write = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        m1_write = 1'b1;
        sample();
        n_checks++;
        if (grant !== 2'b01) $display("FAIL sat_before: got %b want 01", grant);
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if ({grant, m1_waitrequest} !== 3'b100)
            $display("FAIL sat_handoff: got %b want 100", {grant, m1_waitrequest});
        else n_pass++;
        m0_write = 1'b0; m1_write = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        idle_all();
        m0_write = 1'b1; m1_write = 1'b1; s_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            n_checks++;
            if ({grant, m0_waitrequest, m1_waitrequest, s_write} !== 5'b01111)
                $display("FAIL stall cycle %0d: got %b want 01111", i,
                         {grant, m0_waitrequest, m1_waitrequest, s_write});
            else n_pass++;
        end
        tick();
        s_waitrequest = 1'b0;
        sample();
        n_checks++;
        if ({grant, m0_waitrequest} !== 3'b010)
            $display("FAIL stall_complete: got %b want 010", {grant, m0_waitrequest});
        else n_pass++;
        tick();
        m0_write = 1'b0;
        sample();
        n_checks++;
        if ({grant, s_write} !== 3'b010)
            $display("FAIL stall_release: got %b want 010", {grant, s_write});
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if ({grant, s_write, m1_waitrequest} !== 4'b1010)
            $display("FAIL stall_handoff: got %b want 1010", {grant, s_write, m1_waitrequest});
        else n_pass++;
        m1_write = 1'b0;
        tick();
    endtask

    task automatic test_read();
        idle_all();
        m1_address = 16'h0010; m1_read = 1'b1; s_waitrequest = 1'b1;
        tick();
        sample();
        n_checks++;
        if ({grant, s_read, s_address, m1_waitrequest} !== {3'b101, 16'h0010, 1'b1})
            $display("FAIL read_issue: got %b %b %h %b want 10 1 0010 1",
                     grant, s_read, s_address, m1_waitrequest);
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if (m1_waitrequest !== 1'b1) $display("FAIL read_wait: got %b want 1", m1_waitrequest);
        else n_pass++;
        tick();
        s_waitrequest = 1'b0; s_readdata = 16'h1234;
        sample();
        n_checks++;
        if ({m1_readdata, m1_waitrequest, m0_waitrequest} !== {16'h1234, 2'b01})
            $display("FAIL read_data: got %h %b %b want 1234 0 1",
                     m1_readdata, m1_waitrequest, m0_waitrequest);
        else n_pass++;
        tick();
        m1_read = 1'b0; s_readdata = '0;
    endtask

    task automatic test_reset_mid();
        idle_all();
        m1_write = 1'b1; s_waitrequest = 1'b1;
        tick();
        sample();
        n_checks++;
        if ({grant, s_write} !== 3'b101)
            $display("FAIL mid_grant: got %b want 101", {grant, s_write});
        else n_pass++;
        tick();
        sysreset = 1'b1;
        sample();
        n_checks++;
        if (s_write !== 1'b1) $display("FAIL mid_before_edge: got %b want 1", s_write);
        else n_pass++;
        tick();
        sample();
        n_checks++;
        if ({s_write, grant, m1_waitrequest} !== 4'b0001)
            $display("FAIL mid_reset: got %b want 0001", {s_write, grant, m1_waitrequest});
        else n_pass++;
        sysreset = 1'b0;
        tick();
        sample();
        n_checks++;
        if (grant !== 2'b10) $display("FAIL mid_regrant: got %b want 10", grant);
        else n_pass++;
        m1_write = 1'b0; s_waitrequest = 1'b0;
        tick();
    endtask

    initial begin
        sysreset = 1'b1;
        m0_address = '0; m0_writedata = '0; m0_write = 1'b0; m0_read = 1'b0;
        m1_address = '0; m1_writedata = '0; m1_write = 1'b0; m1_read = 1'b0;
        s_readdata = '0; s_waitrequest = 1'b0;
        test_reset();
        test_solo_write();
        test_contention();
        test_hold_saturate();
        test_stall();
        test_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
